// File: rtl/maxnet_pkg.sv
// Shared constants and state encoding for the Maxnet operand store writer.
package maxnet_pkg;

    localparam int DATA_W    = 32;
    localparam int N         = 4;
    localparam int NW        = N * N;
    localparam int FRAME_LEN = N + NW;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int IDX_W     = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        LOAD_X = 2'd0,
        LOAD_W = 2'd1,
        FULL   = 2'd2
    } state_t;

endpackage

// File: rtl/maxnet_mem_writer_if.sv
// Word stream, release handshake and flat operand buses between source/consumer and writer.
interface maxnet_mem_writer_if;
    import maxnet_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    // "release" is a reserved word, hence the suffix
    logic                   release_pulse;
    logic [N*DATA_W-1:0]    x_flat;
    logic [NW*DATA_W-1:0]   w_flat;
    logic                   mem_valid;
    logic                   start;
    logic [CNT_W-1:0]       word_cnt;

    modport master (
        output in_valid, in_data, release_pulse,
        input  in_ready, x_flat, w_flat, mem_valid, start, word_cnt
    );

    modport slave (
        input  in_valid, in_data, release_pulse,
        output in_ready, x_flat, w_flat, mem_valid, start, word_cnt
    );

endinterface

// File: rtl/maxnet_mem_writer_regfile.sv
// Frame register file: one write port by slot index, flat read-out, synchronous clear.
module maxnet_word_regfile
    import maxnet_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_we,
    input  logic [IDX_W-1:0]              i_idx,
    input  logic [DATA_W-1:0]             i_data,
    output logic [FRAME_LEN*DATA_W-1:0]   o_flat
);

    logic [DATA_W-1:0] r_mem [FRAME_LEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_we && (i_idx < IDX_W'(FRAME_LEN))) begin
            r_mem[i_idx] <= i_data;
        end
    end

    for (genvar g = 0; g < FRAME_LEN; g++) begin : g_flat
        assign o_flat[g*DATA_W +: DATA_W] = r_mem[g];
    end

endmodule

// File: rtl/maxnet_mem_writer.sv
// Loads X then W words into the frame store, flags a complete frame and waits for release.
module maxnet_mem_writer
    import maxnet_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    maxnet_mem_writer_if.slave bus
);

    state_t                      r_state;
    state_t                      w_next_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_next_cnt;
    logic                        r_mem_valid;
    logic                        w_next_mem_valid;
    logic                        r_start;
    logic                        w_next_start;
    logic                        w_in_ready;
    logic                        w_accept;
    logic                        w_we;
    logic [FRAME_LEN*DATA_W-1:0] w_flat_all;

    // Ready is a pure state decode so there is no path from in_valid to in_ready
    assign w_in_ready = (r_state != FULL);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD_X;
            r_cnt       <= '0;
            r_mem_valid <= 1'b0;
            r_start     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_mem_valid <= w_next_mem_valid;
            r_start     <= w_next_start;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_cnt       = r_cnt;
        w_next_mem_valid = r_mem_valid;
        w_next_start     = 1'b0;
        w_we             = 1'b0;
        case (r_state)
            LOAD_X: begin
                if (w_accept) begin
                    w_we       = 1'b1;
                    w_next_cnt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N - 1)) begin
                        w_next_state = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (w_accept) begin
                    w_we       = 1'b1;
                    w_next_cnt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
                        w_next_state     = FULL;
                        w_next_mem_valid = 1'b1;
                        w_next_start     = 1'b1;
                    end
                end
            end
            FULL: begin
                // Counter parks at FRAME_LEN here, which is what keeps it from wrapping
                if (bus.release_pulse) begin
                    w_next_state     = LOAD_X;
                    w_next_mem_valid = 1'b0;
                    w_next_cnt       = '0;
                end
            end
            default: begin
                w_next_state = LOAD_X;
            end
        endcase
    end

    maxnet_word_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_we),
        .i_idx  (r_cnt[IDX_W-1:0]),
        .i_data (bus.in_data),
        .o_flat (w_flat_all)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.x_flat    = w_flat_all[N*DATA_W-1:0];
    assign bus.w_flat    = w_flat_all[FRAME_LEN*DATA_W-1:N*DATA_W];
    assign bus.mem_valid = r_mem_valid;
    assign bus.start     = r_start;
    assign bus.word_cnt  = r_cnt;

endmodule

// File: tb/tb_maxnet_mem_writer.sv
// Directed and randomized frames against a slot-array reference model of the operand store.
module tb_maxnet_mem_writer;
    import maxnet_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    maxnet_mem_writer_if bus ();

    maxnet_mem_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int testsRun  = 0;
    int failCount = 0;
    int cycleNo   = 0;

    // Reference model: frame contents as a slot array plus a frame-complete flag
    logic [31:0] modelMem [FRAME_LEN];
    int          modelCnt   = 0;
    bit          modelFull  = 1'b0;
    bit          modelStart = 1'b0;
    string       stepTag    = "init";

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input bit v, input logic [31:0] d, input bit rel, input bit r);
        modelStart = 1'b0;
        if (r) begin
            for (int k = 0; k < FRAME_LEN; k++) modelMem[k] = '0;
            modelCnt  = 0;
            modelFull = 1'b0;
        end else if (!modelFull) begin
            if (v) begin
                modelMem[modelCnt] = d;
                modelCnt++;
                if (modelCnt == FRAME_LEN) begin
                    modelFull  = 1'b1;
                    modelStart = 1'b1;
                end
            end
        end else if (rel) begin
            modelFull = 1'b0;
            modelCnt  = 0;
        end
    endtask

    task automatic checkAll();
        logic [N*32-1:0]  expX;
        logic [NW*32-1:0] expW;
        for (int k = 0; k < N; k++)  expX[k*32 +: 32] = modelMem[k];
        for (int k = 0; k < NW; k++) expW[k*32 +: 32] = modelMem[N+k];
        checkOutput({stepTag, " x_flat"},    512'(bus.x_flat),    512'(expX));
        checkOutput({stepTag, " w_flat"},    512'(bus.w_flat),    512'(expW));
        checkOutput({stepTag, " word_cnt"},  512'(bus.word_cnt),  512'(modelCnt));
        checkOutput({stepTag, " mem_valid"}, 512'(bus.mem_valid), 512'(modelFull));
        checkOutput({stepTag, " start"},     512'(bus.start),     512'(modelStart));
        checkOutput({stepTag, " in_ready"},  512'(bus.in_ready),  512'(!modelFull));
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later
    task automatic applyStimulus(input bit v, input logic [31:0] d, input bit rel, input bit r);
        bus.in_valid      = v;
        bus.in_data       = d;
        bus.release_pulse = rel;
        rst               = r;
        @(posedge clk);
        cycleNo++;
        modelStep(v, d, rel, r);
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom, 1'b0, 1'b0);
    endtask

    logic [31:0] frameA [FRAME_LEN];
    int          startCycle;
    int          firstCycle;

    initial begin
        for (int k = 0; k < FRAME_LEN; k++) modelMem[k] = '0;
        for (int k = 0; k < N; k++)  frameA[k]   = 32'((k + 1) * 10);
        for (int k = 0; k < NW; k++) frameA[N+k] = 32'(k + 1);
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.release_pulse = 1'b0;

        stepTag = "reset";
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        idle(1);

        stepTag = "burst";
        for (int k = 0; k < FRAME_LEN; k++) applyStimulus(1'b1, frameA[k], 1'b0, 1'b0);
        checkOutput("burst x0",  512'(bus.x_flat[31:0]),    512'(32'd10));
        checkOutput("burst x3",  512'(bus.x_flat[127:96]),  512'(32'd40));
        checkOutput("burst w15", 512'(bus.w_flat[511:480]), 512'(32'd16));
        checkOutput("burst start", 512'(bus.start), 512'(1'b1));
        idle(1);
        checkOutput("burst start pulse", 512'(bus.start), 512'(1'b0));

        stepTag = "full_hold";
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        stepTag = "release_valid";
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        checkOutput("reload x0", 512'(bus.x_flat[31:0]), 512'(32'hDEADBEEF));

        stepTag = "midreset";
        for (int k = 1; k < 7; k++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("midreset cnt", 512'(bus.word_cnt), 512'(0));

        stepTag = "gapped";
        firstCycle = cycleNo;
        startCycle = -1;
        for (int k = 0; k < FRAME_LEN; k++) begin
            applyStimulus(1'b0, $urandom, 1'b0, 1'b0);
            applyStimulus(1'b1, frameA[k], 1'b0, 1'b0);
            if (bus.start === 1'b1) startCycle = cycleNo - firstCycle;
        end
        checkOutput("gapped start cycle", 512'(startCycle), 512'(40));
        checkOutput("gapped x3",  512'(bus.x_flat[127:96]),  512'(32'd40));
        checkOutput("gapped w15", 512'(bus.w_flat[511:480]), 512'(32'd16));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        stepTag = "release_in_load_w";
        for (int k = 0; k < FRAME_LEN; k++) begin
            applyStimulus(1'b1, $urandom, (k == 12), 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        stepTag = "negative";
        for (int k = 0; k < FRAME_LEN; k++) begin
            applyStimulus(1'b1, (k == 2) ? 32'hFFFFFFFF : (k == FRAME_LEN - 1) ? 32'h80000000 : 32'h0,
                          1'b0, 1'b0);
        end
        checkOutput("negative x2",  512'(bus.x_flat[95:64]),   512'(32'hFFFFFFFF));
        checkOutput("negative w15", 512'(bus.w_flat[511:480]), 512'(32'h80000000));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        stepTag = "random";
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 200 && !modelFull; i++) begin
                applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) == 0, 1'b0);
            end
            checkOutput("random frame complete", 512'(bus.mem_valid), 512'(1'b1));
            for (int i = 0; i < 3; i++) applyStimulus($urandom_range(0, 1) == 1, $urandom, 1'b0, 1'b0);
            applyStimulus($urandom_range(0, 1) == 1, $urandom, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/maxnet_mem_writer.md
# maxnet_mem_writer

Loads the Maxnet operand store over a 32-bit valid/ready word stream: N activation words (X) followed by N*N weight words (W, row-major, row i feeding PU i+1). It holds the frame in registers, presents it as flat buses to the datapath's memory inputs, and pulses `start` to the controller once the frame is complete. It refuses further input until the consumer returns `release` after the winner is read out.

## Interface
- `DATA_W`, 32, width of one X/W word
- `N`, 4, number of activations/PUs; weight count is N*N (fixed 4 for the current datapath)

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  source has a word on `in_data`
- `in_ready`  out  1  writer accepts a word this cycle
- `in_data`  in  DATA_W  X or W word, stream order X[0..N-1], W[0..N*N-1]
- `release`  in  1  one-cycle pulse from the consumer; frame consumed
- `x_flat`  out  N*DATA_W  X[k] at bits [k*DATA_W +: DATA_W]
- `w_flat`  out  N*N*DATA_W  W[k] at bits [k*DATA_W +: DATA_W]
- `mem_valid`  out  1  complete frame held, contents stable
- `start`  out  1  one-cycle pulse when the frame completes
- `word_cnt`  out  clog2(N+N*N+1)  words accepted in the current frame

## Operation
- Reset clears the state to LOAD_X, `word_cnt` 0, all X/W registers 0, and `mem_valid`, `start` 0. `in_ready` is 1 from the first cycle after reset.
- A word is accepted when `in_valid && in_ready` is high at the clock edge. The accepted word is written to slot `word_cnt`: slots 0..N-1 are X, slots N..N+N*N-1 are W[word_cnt-N]. `word_cnt` then increments.
- States:
  - LOAD_X: `in_ready`=1. On accepting X[N-1], go to LOAD_W.
  - LOAD_W: `in_ready`=1. On accepting W[N*N-1], go to FULL; `mem_valid`<=1, `start`<=1 for exactly one cycle, `word_cnt` holds N+N*N.
  - FULL: `in_ready`=0, and the registers hold their values. On `release`, go to LOAD_X; `mem_valid`<=0, `word_cnt`<=0.
- `release` outside FULL is ignored.
- `in_valid` low stalls the transfer with no state change. Gaps between words are allowed anywhere.
- `in_data` is unchecked; all values, including 0 and negative two's-complement, are stored verbatim.
- `x_flat`/`w_flat` always show register contents. During reload, unwritten slots keep the previous frame's values; consumers may only sample while `mem_valid`=1.

## Timing
- A word accepted at edge t is visible on `x_flat`/`w_flat` after edge t.
- Minimum frame time is N+N*N cycles (20 for N=4) at one word per cycle.
- `mem_valid` and `start` rise together after the edge that accepts the last W.
- `in_ready` is a registered-state decode with no combinational path from `in_valid`. In the cycle where `release` is sampled, `in_ready` is still 0. The first new word can be accepted at the next edge.
- `rst` has priority over every event, including a mid-frame transfer or `release`. The partial frame is discarded and all registers are zeroed at that edge.
- If `release` and `in_valid` are high together in FULL, no word is taken that cycle.
- `word_cnt` never wraps. The FULL state blocks the increment past N+N*N.

## Structure
- Shared `maxnet_pkg` holds the `DATA_W` default, N, the derived `NW = N*N` and `FRAME_LEN = N+NW` constants, and the state encoding (LOAD_X, LOAD_W, FULL).
- One sub-module, `maxnet_word_regfile`: FRAME_LEN×DATA_W registers with a write-enable and write-index. It has flat read-out and a synchronous clear on `rst`.
- The top level holds the FSM, the counter and the handshake.

## Test plan
- Reset, then stream X=10,20,30,40 and W=1..16 with `in_valid` held high → accepted at 20 consecutive edges. Then `x_flat[31:0]`=10, `x_flat[127:96]`=40, `w_flat[511:480]`=16. `mem_valid`=1 and `start` is a single-cycle pulse, both after the 20th edge.
- Same stream with `in_valid` low every other cycle → identical final contents, `start` after 40 cycles, `word_cnt` stalls during the gaps.
- In FULL, hold `in_valid`=1 with `in_data`=0xDEADBEEF for 5 cycles → `in_ready`=0 and no register changes. Pulse `release` → `mem_valid`=0, `word_cnt`=0. 0xDEADBEEF lands in X[0] one cycle later.
- Assert `rst` after 7 accepted words → all outputs 0 on the next cycle. A full fresh 20-word frame then loads correctly from X[0].
- `release` pulsed during LOAD_W at `word_cnt`=12 → ignored. Loading continues and completes at the 20th word.
- Negative values (0xFFFFFFFF in X[2], 0x80000000 in W[15]) → stored unchanged.
